eaglesong_stream_frontend: RTL and testbench
============================================

# eaglesong_stream_frontend

Initiator-side front end for `eaglesong_digest_top`. It collects a byte stream message of 1–32 bytes into the core's 256-bit input word, pulses `start_eval`, and waits for `eval_output_ready` under a timeout. It then returns the 32-byte digest as a byte stream. It sits between the host byte interface and the digest core, and it replaces the hand-driven stimulus used to exercise the core so far.

## Interface
- `START_CYCLES`, default 1: number of cycles `core_start_eval` is held high; legal range 1..4.
- `TIMEOUT`, default 120: maximum number of WAIT cycles before the run is abandoned.
- `clk` in 1: system clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in 8: message byte.
- `in_valid` in 1: `in_data` is valid.
- `in_last` in 1: this byte ends the message.
- `in_ready` out 1: a byte is accepted when `in_valid && in_ready`.
- `out_data` out 8: digest byte.
- `out_valid` out 1: `out_data` is valid.
- `out_last` out 1: this is digest byte 31.
- `out_ready` in 1: a byte transfers when `out_valid && out_ready`.
- `core_input_val` out 256: message bytes; byte k occupies bits [8k+7:8k].
- `core_input_length_bytes` out 7: message length, 1..32.
- `core_start_eval` out 1: start pulse to the core.
- `core_output_val` in 256: digest; byte k occupies bits [8k+7:8k].
- `core_eval_output_ready` in 1: the digest is valid.
- `busy` out 1: high in any state other than COLLECT.
- `err_overflow` out 1: one-cycle pulse.
- `err_timeout` out 1: one-cycle pulse.

## Operation
- **Reset values:** all outputs are 0; `core_input_val` and `core_input_length_bytes` are 0; the state is COLLECT.
- **COLLECT:**
  - `in_ready` is 1.
  - Each accepted byte is written to byte slot `cnt`, then `cnt` increments (6 bits).
  - Slots at index `cnt` and above are zero in `core_input_val`.
  - On an accepted byte with `in_last`:
    - if total ≤ 32: length = total, go to START;
    - if total > 32: pulse `err_overflow`, clear the buffer and `cnt`, stay in COLLECT.
  - Bytes beyond the 32nd are accepted and discarded; the overflow flag is sticky until `in_last`.
- **START:**
  - `core_start_eval` is 1 for exactly `START_CYCLES` cycles.
  - `core_input_val` and `core_input_length_bytes` stay stable from START entry until return to COLLECT.
  - `in_ready` is 0 here and in every later state.
- **WAIT:**
  - The timeout counter counts up from 0.
  - First cycle with `core_eval_output_ready` = 1: register `core_output_val` into the digest buffer, go to SEND.
  - Counter reaches `TIMEOUT` with no ready: pulse `err_timeout`, go to COLLECT, emit no output.
- **SEND:**
  - `out_data` = digest byte `idx` (`idx` is 5 bits, starting at 0).
  - `out_valid` = 1; `out_last` = (`idx` == 31).
  - On transfer, `idx` increments; the transfer at `idx` 31 returns to COLLECT and clears `cnt`.
  - `out_data` is held stable while `out_ready` = 0.
- **Reset mid-operation:** behaves as a normal reset. Any partial message or digest is dropped, and `core_start_eval` drops immediately.

## Timing
- Last input byte accepted at edge N → `core_start_eval` high for cycles N+1 .. N+`START_CYCLES`.
- WAIT begins on the cycle after the last start cycle.
- Ready sampled at edge M → `out_valid` = 1 from cycle M+1.
- With `out_ready` held at 1, the 32 bytes leave in 32 consecutive cycles.
- Minimum turnaround: 1 cycle after the last output transfer, `in_ready` = 1.
- Simultaneous ready and timeout-expiry in the same cycle: ready wins.

## Structure
- Package `eaglesong_pkg` holds:
  - `DIGEST_BYTES` = 32 and `MAX_MSG_BYTES` = 32;
  - the state enum (COLLECT, START, WAIT, SEND).
- One sub-module, `eaglesong_byte_serializer`: 256-bit load, 8-bit valid/ready out, `last`.

## Test plan
- **Hello world:** stream 48 65 6C 6C 6F 2C 20 77 6F 72 6C 64 21 0A with `in_last` on 0A.
  - `core_input_val` = 256'h0A21646C726F77202C6F6C6C6548, length 14.
  - Exactly one start cycle.
  - With the real core attached, the output bytes are 64 86 7E 24 … 7D 72 D6, and `out_last` is on D6.
- **Overflow:** stream 33 bytes. `err_overflow` pulses on byte 33, `core_start_eval` never rises, and the next 1-byte message (0x61) runs normally with length 1.
- **Timeout:** stub core that never asserts ready. `err_timeout` pulses exactly `TIMEOUT` cycles after WAIT entry, `out_valid` stays 0, and `in_ready` = 1 on the following cycle.
- **Backpressure:** toggle `out_ready` 1/0 each cycle. All 32 bytes arrive in order, and `out_data` is stable while stalled.
- **Boundary length:** exactly 32 bytes 00..1F. `core_input_length_bytes` = 32, `core_input_val[255:248]` = 1F, no overflow.
- **Reset mid-WAIT:** assert `rst_n` = 0 during WAIT. All outputs go to 0 asynchronously, and after release a new message runs cleanly.

Source files
------------

// File: rtl/eaglesong_pkg.sv
// Shared sizes and FSM encoding for the Eaglesong stream front end.
package eaglesong_pkg;

  localparam int DIGEST_BYTES  = 32;
  localparam int MAX_MSG_BYTES = 32;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    SEND    = 2'd3
  } state_e;

endpackage

// File: rtl/eaglesong_byte_serializer.sv
// Holds a 256-bit digest and emits it byte 0 first; byte 0 is valid the cycle after load.
// Backpressure: out_dat/out_last hold while out_rdy is low; out_dat reads 0 when idle.
module eaglesong_byte_serializer
  import eaglesong_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_vld,
  input  logic [255:0] load_dat,
  output logic [7:0]   out_dat,
  output logic         out_vld,
  output logic         out_last,
  input  logic         out_rdy
);

  localparam logic [4:0] LAST_IDX = 5'(DIGEST_BYTES - 1);

  logic [255:0] dig_q, dig_d;
  logic [4:0]   idx_q, idx_d;
  logic         vld_q, vld_d;

  always_comb begin
    dig_d = dig_q;
    idx_d = idx_q;
    vld_d = vld_q;
    if (load_vld) begin
      dig_d = load_dat;
      idx_d = '0;
      vld_d = 1'b1;
    end else if (vld_q && out_rdy) begin
      // Index wraps back to 0 after the final byte, ready for the next load.
      idx_d = idx_q + 5'd1;
      if (idx_q == LAST_IDX) begin
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
    end else begin
      dig_q <= dig_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
    end
  end

  always_comb begin
    out_vld  = vld_q;
    out_last = vld_q && (idx_q == LAST_IDX);
    out_dat  = vld_q ? dig_q[{idx_q, 3'b000} +: 8] : 8'h00;
  end

endmodule

// File: rtl/eaglesong_stream_frontend.sv
// Packs a 1-32 byte message for the digest core, starts it, waits with timeout, streams the digest.
// Latency: start the cycle after the last byte; in_ready drops while busy; digest output honours out_ready.
module eaglesong_stream_frontend
  import eaglesong_pkg::*;
#(
  parameter int START_CYCLES = 1,
  parameter int TIMEOUT      = 120
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic [255:0] core_input_val,
  output logic [6:0]   core_input_length_bytes,
  output logic         core_start_eval,
  input  logic [255:0] core_output_val,
  input  logic         core_eval_output_ready,
  output logic         busy,
  output logic         err_overflow,
  output logic         err_timeout
);

  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0]  SC_LAST  = 2'(START_CYCLES - 1);
  localparam logic [5:0]  MSG_FULL = 6'(MAX_MSG_BYTES);

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [255:0]    msg_q, msg_d;
  logic [6:0]      len_q, len_d;
  logic [1:0]      sc_q, sc_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            in_rdy_q, in_rdy_d;
  logic            err_ovf_q, err_ovf_d;
  logic            err_tmo_q, err_tmo_d;

  logic accept, msg_too_long, core_load, tmo_expire, tx_last;

  assign accept       = in_valid && in_rdy_q && (state_q == COLLECT);
  assign msg_too_long = ovf_q || (cnt_q == MSG_FULL);
  assign core_load    = (state_q == WAIT) && core_eval_output_ready;
  assign tmo_expire   = (state_q == WAIT) && !core_eval_output_ready && (tmo_q == TMO_LAST);
  assign tx_last      = out_valid && out_ready && out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept && in_last && !msg_too_long) state_d = START;
      START:   if (sc_q == SC_LAST) state_d = WAIT;
      WAIT: begin
        // A ready arriving in the final WAIT cycle still wins over expiry.
        if (core_eval_output_ready) state_d = SEND;
        else if (tmo_q == TMO_LAST) state_d = COLLECT;
      end
      SEND:    if (tx_last) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    msg_d     = msg_q;
    len_d     = len_q;
    sc_d      = '0;
    tmo_d     = '0;
    err_ovf_d = 1'b0;
    err_tmo_d = tmo_expire;
    in_rdy_d  = (state_d == COLLECT);
    if (state_q == START) sc_d = sc_q + 2'd1;
    if (state_q == WAIT) tmo_d = tmo_q + TW'(1);
    if (accept) begin
      if (cnt_q < MSG_FULL) begin
        msg_d[{cnt_q[4:0], 3'b000} +: 8] = in_data;
        cnt_d = cnt_q + 6'd1;
      end else begin
        ovf_d = 1'b1;
      end
      if (in_last) begin
        if (msg_too_long) begin
          msg_d     = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          err_ovf_d = 1'b1;
        end else begin
          len_d = {1'b0, cnt_q} + 7'd1;
        end
      end
    end
    // Leaving a run clears the buffer so unwritten slots read as zero next time.
    if ((state_q != COLLECT) && (state_d == COLLECT)) begin
      msg_d = '0;
      len_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      msg_q     <= '0;
      len_q     <= '0;
      sc_q      <= '0;
      tmo_q     <= '0;
      in_rdy_q  <= 1'b0;
      err_ovf_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      msg_q     <= msg_d;
      len_q     <= len_d;
      sc_q      <= sc_d;
      tmo_q     <= tmo_d;
      in_rdy_q  <= in_rdy_d;
      err_ovf_q <= err_ovf_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  always_comb begin
    core_start_eval         = (state_q == START);
    busy                    = (state_q != COLLECT);
    in_ready                = in_rdy_q;
    err_overflow            = err_ovf_q;
    err_timeout             = err_tmo_q;
    core_input_val          = msg_q;
    core_input_length_bytes = len_q;
  end

  eaglesong_byte_serializer u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_vld (core_load),
    .load_dat (core_output_val),
    .out_dat  (out_data),
    .out_vld  (out_valid),
    .out_last (out_last),
    .out_rdy  (out_ready)
  );

endmodule

// File: tb/tb_eaglesong_stream_frontend.sv
// Randomised scoreboard bench for eaglesong_stream_frontend with a behavioural stub digest core.
module tb_eaglesong_stream_frontend;

  localparam int SC  = 1;
  localparam int TMO = 120;
  localparam logic [7:0] HW [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                                     8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

  typedef struct packed {
    logic [255:0] val;
    logic [6:0]   len;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_data;
  logic         in_valid, in_last, in_ready;
  logic [7:0]   out_data;
  logic         out_valid, out_last, out_ready;
  logic [255:0] core_input_val, core_output_val;
  logic [6:0]   core_input_length_bytes;
  logic         core_start_eval, core_eval_output_ready;
  logic         busy, err_overflow, err_timeout;

  eaglesong_stream_frontend #(.START_CYCLES(SC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .core_input_val(core_input_val), .core_input_length_bytes(core_input_length_bytes),
    .core_start_eval(core_start_eval), .core_output_val(core_output_val),
    .core_eval_output_ready(core_eval_output_ready),
    .busy(busy), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t        exp_q[$];
  logic [8:0]  sb_q[$];
  logic [7:0]  msg[$];
  int rdy_mode = 0;
  bit core_respond = 1'b1;
  int core_delay_fixed = -1;
  int n_ovf = 0, n_tmo = 0, n_tx = 0;
  int exp_ovf = 0, exp_tmo = 0;
  int vld_due = -1;

  // Stub core: answers each start with a random digest after a chosen delay.
  initial begin
    logic [255:0] dig;
    bit prev;
    int k;
    prev = 1'b0;
    core_eval_output_ready = 1'b0;
    core_output_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (prev && !core_start_eval && core_respond) begin
          k = (core_delay_fixed >= 0) ? core_delay_fixed : $urandom_range(0, 20);
          repeat (k) @(negedge clk);
          dig = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
          core_output_val = dig;
          core_eval_output_ready = 1'b1;
          for (int i = 0; i < 32; i++) sb_q.push_back({(i == 31), dig[8*i +: 8]});
          vld_due = cyc + 1;
          @(negedge clk);
          core_eval_output_ready = 1'b0;
          core_output_val = ~dig;
        end
        prev = core_start_eval;
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = !out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: models input framing, start timing, timeout timing and the output scoreboard.
  initial begin
    int acc_len, start_due, ovf_due, wait_cyc, turn_due, start_run;
    bit start_prev, run_act, stalled;
    logic [7:0] held;
    logic [8:0] b;
    exp_t cur;
    acc_len = 0; start_due = -1; ovf_due = -1; wait_cyc = -100000; turn_due = -1;
    start_run = 0; start_prev = 0; run_act = 0; stalled = 0; held = '0; cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_len = 0; start_prev = 0; run_act = 0; stalled = 0; start_run = 0;
      end else begin
        if (core_start_eval) begin
          if (!start_prev) begin
            chk("start_timing", cyc, start_due);
            chk("start_has_msg", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              cur = exp_q.pop_front();
              chk("core_input_val", core_input_val, cur.val);
              chk("core_input_len", core_input_length_bytes, cur.len);
              run_act = 1'b1;
            end
            start_run = 0;
          end
          start_run++;
        end else if (start_prev) begin
          chk("start_cycles", start_run, SC);
          wait_cyc = cyc;
        end
        start_prev = core_start_eval;
        if (run_act && busy) chk("input_stable", {core_input_val, core_input_length_bytes}, cur);
        if (!busy) run_act = 1'b0;

        if (err_overflow) begin
          n_ovf++;
          chk("ovf_timing", cyc, ovf_due);
        end
        if (err_timeout) begin
          n_tmo++;
          chk("tmo_timing", cyc, wait_cyc + TMO);
          chk("tmo_in_ready", in_ready, 1);
        end

        if (cyc == vld_due) chk("out_valid_latency", out_valid, 1);
        if (stalled) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, held);
        end
        stalled = 0;
        if (out_valid) begin
          if (out_ready) begin
            n_tx++;
            chk("out_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
              b = sb_q.pop_front();
              chk("out_data", out_data, b[7:0]);
              chk("out_last", out_last, b[8]);
              if (b[8]) turn_due = cyc + 1;
            end
          end else begin
            stalled = 1'b1;
            held = out_data;
          end
        end
        if (cyc == turn_due) chk("turnaround_in_ready", in_ready, 1);

        if (in_valid && in_ready) begin
          acc_len++;
          if (in_last) begin
            if (acc_len > 32) ovf_due = cyc + 1;
            else start_due = cyc + 1;
            acc_len = 0;
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_start"}, core_start_eval, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err_ovf"}, err_overflow, 0);
    chk({tag, "_err_tmo"}, err_timeout, 0);
    chk({tag, "_core_val"}, core_input_val, 0);
    chk({tag, "_core_len"}, core_input_length_bytes, 0);
  endtask

  task automatic fill_rand(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
  endtask

  // Called just after a rising edge; returns just after the edge that took the last byte.
  task automatic send_cur(input bit push_exp);
    logic [255:0] v;
    int t;
    v = '0;
    if (push_exp) begin
      for (int i = 0; i < msg.size(); i++) v[8*i +: 8] = msg[i];
      exp_q.push_back({v, 7'(msg.size())});
    end
    for (int i = 0; i < msg.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = msg[i];
      in_last  = (i == msg.size() - 1);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 400) begin
        @(negedge clk);
        t++;
      end
      chk("in_handshake", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || sb_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_reached", {busy, sb_q.size() != 0}, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, t, len;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    #3;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Hello world
    msg.delete();
    for (int i = 0; i < 14; i++) msg.push_back(HW[i]);
    send_cur(1);
    chk("hello_val", core_input_val, 256'h0A21646C726F77202C6F6C6C6548);
    chk("hello_len", core_input_length_bytes, 14);
    wait_idle();

    // Backpressure toggling every cycle
    rdy_mode = 1;
    n0 = n_tx;
    fill_rand($urandom_range(1, 32));
    send_cur(1);
    wait_idle();
    chk("bp_byte_count", n_tx - n0, 32);
    rdy_mode = 0;

    // Boundary: exactly 32 bytes 00..1F
    n0 = n_ovf;
    msg.delete();
    for (int i = 0; i < 32; i++) msg.push_back(8'(i));
    send_cur(1);
    chk("bound_len", core_input_length_bytes, 32);
    chk("bound_top_byte", core_input_val[255:248], 8'h1F);
    wait_idle();
    chk("bound_no_ovf", n_ovf, n0);

    // Overflow with 33 bytes, then a 1-byte message
    n0 = n_ovf;
    fill_rand(33);
    send_cur(0);
    exp_ovf++;
    repeat (3) @(negedge clk);
    chk("ovf_pulsed", n_ovf, n0 + 1);
    chk("ovf_in_ready", in_ready, 1);
    chk("ovf_not_busy", busy, 0);
    @(posedge clk);
    #1;
    msg.delete();
    msg.push_back(8'h61);
    send_cur(1);
    chk("after_ovf_len", core_input_length_bytes, 1);
    chk("after_ovf_val", core_input_val, 256'h61);
    wait_idle();

    // Timeout with a silent core
    core_respond = 1'b0;
    n0 = n_tmo;
    fill_rand($urandom_range(1, 32));
    send_cur(1);
    exp_tmo++;
    t = 0;
    while (n_tmo == n0 && t < TMO + 40) begin
      @(negedge clk);
      t++;
    end
    chk("tmo_seen", n_tmo, n0 + 1);
    core_respond = 1'b1;
    wait_idle();

    // Ready in the last WAIT cycle wins over expiry
    core_delay_fixed = TMO - 1;
    fill_rand($urandom_range(1, 32));
    send_cur(1);
    wait_idle();
    core_delay_fixed = -1;

    // Reset while waiting for the core
    core_respond = 1'b0;
    fill_rand($urandom_range(1, 32));
    send_cur(1);
    repeat (SC + 5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("rst_wait");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    core_respond = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fill_rand($urandom_range(1, 32));
    send_cur(1);
    wait_idle();

    // Randomised messages, including some overflows
    for (int r = 0; r < 14; r++) begin
      rdy_mode = $urandom_range(0, 2);
      len = $urandom_range(1, 36);
      fill_rand(len);
      send_cur(len <= 32);
      if (len > 32) exp_ovf++;
      wait_idle();
    end
    rdy_mode = 0;
    repeat (4) @(negedge clk);

    chk("exp_queue_empty", exp_q.size(), 0);
    chk("sb_queue_empty", sb_q.size(), 0);
    chk("ovf_total", n_ovf, exp_ovf);
    chk("tmo_total", n_tmo, exp_tmo);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
